// File: rtl/mem_pkg.sv
// Shared definitions for the program/data memory arbiter: owner encoding,
// master identifiers and default bus widths.
package mem_pkg;

    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 16;

    localparam logic M_CPU    = 1'b0;
    localparam logic M_LOADER = 1'b1;

    // Owner of the most recently accepted transaction; IDLE when none was accepted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    function automatic owner_e owner_of(input logic id);
        return (id == M_LOADER) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_arbiter_lock_timer.sv
// Saturating count of consecutive lock-extended grants; expired marks the point
// where the current owner must yield to a waiting master.
module lock_timer #(
    parameter int LOCK_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(LOCK_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded bus lock between the CPU and the loader for
// the shared synchronous-read memory; read data returns two cycles after the request.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  lock0,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_in,
    output owner_e                state
);

    logic                  any_req;
    logic                  win_id;
    logic                  by_lock;
    logic                  expired;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // acc_* describes the access on the memory port this cycle; rd_* the one
    // whose data arrives on mem_in this cycle.
    logic                  acc_rd;
    logic                  acc_id;
    logic                  rd_pend;
    logic                  rd_id;

    always_comb begin
        any_req = req0 | req1;
        win_id  = M_CPU;
        by_lock = 1'b0;
        if (req0 && req1) begin
            // Only the current owner's lock counts; a non-owner's lock is ignored.
            case (state)
                OWN0: begin
                    if (lock0 && !expired) begin
                        win_id  = M_CPU;
                        by_lock = 1'b1;
                    end else begin
                        win_id = M_LOADER;
                    end
                end
                OWN1: begin
                    if (lock1 && !expired) begin
                        win_id  = M_LOADER;
                        by_lock = 1'b1;
                    end else begin
                        win_id = M_CPU;
                    end
                end
                default: win_id = M_CPU;
            endcase
        end else begin
            win_id = req1 ? M_LOADER : M_CPU;
        end
    end

    always_comb begin
        sel_we    = (win_id == M_LOADER) ? we1    : we0;
        sel_addr  = (win_id == M_LOADER) ? addr1  : addr0;
        sel_wdata = (win_id == M_LOADER) ? wdata1 : wdata0;
    end

    // A lock win implies the other master was requesting; anything else restarts the run.
    lock_timer #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (by_lock),
        .clr     (!by_lock),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            acc_rd   <= 1'b0;
            acc_id   <= M_CPU;
            rd_pend  <= 1'b0;
            rd_id    <= M_CPU;
        end else begin
            rd_pend <= acc_rd;
            rd_id   <= acc_id;
            if (any_req) begin
                state    <= owner_of(win_id);
                gnt0     <= (win_id == M_CPU);
                gnt1     <= (win_id == M_LOADER);
                mem_we   <= sel_we;
                mem_addr <= sel_addr;
                if (sel_we) begin
                    mem_data <= sel_wdata;
                end
                acc_rd   <= !sel_we;
                acc_id   <= win_id;
            end else begin
                state  <= IDLE;
                gnt0   <= 1'b0;
                gnt1   <= 1'b0;
                mem_we <= 1'b0;
                acc_rd <= 1'b0;
            end
        end
    end

    assign rvalid0 = rd_pend && (rd_id == M_CPU);
    assign rvalid1 = rd_pend && (rd_id == M_LOADER);
    assign rdata   = mem_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int LM = 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata, mem_data, mem_in;
  logic [AW-1:0] mem_addr;
  owner_e        state;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_in(mem_in), .state(state)
  );

  // ---------------- memory attached to the port ----------------
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
    mem_in <= mem[mem_addr];
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  int            m_owner;   // -1 = nobody accepted last edge
  int            m_run;     // consecutive grants won through lock
  bit            m_acc_rd;
  int            m_acc_id;
  bit            m_pend;
  int            m_pend_id;
  bit            e_gnt0, e_gnt1, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_acc_rd = 0; m_acc_id = 0; m_pend = 0; m_pend_id = 0;
    e_gnt0 = 0; e_gnt1 = 0; e_we = 0; e_addr = '0; e_data = '0;
    exp_q.delete();
  endtask

  // Applies the arbitration rules to the inputs present at the coming edge.
  task automatic model_edge();
    int  w;
    bit  won_by_lock;
    bit  wwe;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    m_pend    = m_acc_rd;
    m_pend_id = m_acc_id;
    won_by_lock = 0;
    if (!req0 && !req1)      w = -1;
    else if (req0 != req1)   w = req0 ? 0 : 1;
    else if (m_owner < 0)    w = 0;
    else if (((m_owner == 0) ? lock0 : lock1) && m_run < LM) begin
      w = m_owner;
      won_by_lock = 1;
    end else                 w = 1 - m_owner;

    if (w < 0) begin
      e_gnt0 = 0; e_gnt1 = 0; e_we = 0; m_acc_rd = 0; m_owner = -1;
    end else begin
      wwe = (w == 1) ? we1 : we0;
      wa  = (w == 1) ? addr1 : addr0;
      wd  = (w == 1) ? wdata1 : wdata0;
      e_gnt0 = (w == 0); e_gnt1 = (w == 1);
      e_we = wwe; e_addr = wa;
      if (wwe) begin
        e_data = wd;
        ref_mem[wa] = wd;
      end else begin
        exp_q.push_back(ref_mem[wa]);
      end
      m_acc_rd = !wwe; m_acc_id = w; m_owner = w;
    end
    m_run = won_by_lock ? m_run + 1 : 0;
  endtask

  task automatic check_outputs();
    logic [DW-1:0] exp_d;
    check("gnt0", gnt0, e_gnt0);
    check("gnt1", gnt1, e_gnt1);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_data", mem_data, e_data);
    check("rvalid0", rvalid0, m_pend && m_pend_id == 0);
    check("rvalid1", rvalid1, m_pend && m_pend_id == 1);
    check("state", state, (m_owner < 0) ? IDLE : (m_owner == 0) ? OWN0 : OWN1);
    if (m_pend) begin
      if (exp_q.size() == 0) begin
        check("rd_queue", 32'd0, 32'd1);
      end else begin
        exp_d = exp_q.pop_front();
        check("rdata", rdata, exp_d);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive0(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic l);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic l);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
  endtask

  // ---------------- test sequence ----------------
  int run1, g0_cnt;
  bit seen_gnt0;

  initial begin
    drive0(0, 0, '0, '0, 0);
    drive1(0, 0, '0, '0, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'($urandom);
    ref_mem[8] = 16'h1234;
    preload = 1'b1;
    do_reset(3);
    preload = 1'b0;

    // Single read from master 0.
    drive0(1, 0, 6'd8, '0, 0);
    cycle();
    check("t1_gnt0", gnt0, 1);
    drive0(0, 0, '0, '0, 0);
    cycle();
    check("t1_rvalid0", rvalid0, 1);
    check("t1_rdata", rdata, 16'h1234);
    cycle();

    // Both masters reading, no lock: strict alternation starting with master 0.
    drive0(1, 0, 6'd10, '0, 0);
    drive1(1, 0, 6'd20, '0, 0);
    g0_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      g0_cnt += gnt0;
    end
    check("rr_gnt0_count", g0_cnt, 3);
    drive0(0, 0, '0, '0, 0);
    drive1(0, 0, '0, '0, 0);
    cycle();
    cycle();

    // Locked burst writes from the loader against a waiting CPU.
    drive0(1, 0, 6'd1, '0, 0);
    cycle();
    drive1(1, 1, 6'd3, 16'hBEEF, 1);
    run1 = 0;
    seen_gnt0 = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (!seen_gnt0 && gnt1) run1++;
      if (gnt0 && !seen_gnt0) begin
        seen_gnt0 = 1;
        check("lock_yield_at", i, 9);
      end
    end
    check("lock_run_len", run1, 9);
    drive0(0, 0, '0, '0, 0);
    drive1(0, 0, '0, '0, 0);
    cycle();
    cycle();
    check("mem3_written", mem[3], 16'hBEEF);
    drive1(1, 0, 6'd3, '0, 0);
    cycle();
    drive1(0, 0, '0, '0, 0);
    cycle();
    check("t3_rdata", rdata, 16'hBEEF);
    cycle();

    // Write then immediate read of the same address.
    drive0(1, 1, 6'd5, 16'h00AA, 0);
    cycle();
    check("t4_we_hi", mem_we, 1);
    drive0(1, 0, 6'd5, '0, 0);
    cycle();
    check("t4_we_lo", mem_we, 0);
    drive0(0, 0, '0, '0, 0);
    cycle();
    check("t4_rvalid0", rvalid0, 1);
    check("t4_rdata", rdata, 16'h00AA);
    cycle();

    // Reset with a read in flight, then a tie after release.
    drive0(1, 0, 6'd8, '0, 0);
    cycle();
    check("t5_gnt0", gnt0, 1);
    drive0(0, 0, '0, '0, 0);
    do_reset(2);
    check("t5_rvalid0", rvalid0, 0);
    cycle();
    check("t5_rvalid0_after", rvalid0, 0);
    drive0(1, 0, 6'd2, '0, 0);
    drive1(1, 0, 6'd4, '0, 0);
    cycle();
    check("t5_tie_gnt0", gnt0, 1);
    drive0(0, 0, '0, '0, 0);
    drive1(0, 0, '0, '0, 0);
    cycle();
    cycle();

    // Random traffic; a master holds its transaction until granted.
    for (int i = 0; i < 600; i++) begin
      if (e_gnt0 || !req0)
        drive0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom),
               DW'($urandom), $urandom_range(0, 2) != 0);
      if (e_gnt1 || !req1)
        drive1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom),
               DW'($urandom), $urandom_range(0, 2) != 0);
      cycle();
    end
    drive0(0, 0, '0, '0, 0);
    drive1(0, 0, '0, '0, 0);
    cycle();
    cycle();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
